// File: rtl/s5_mbox.sv
// rtl/s5_mbox.sv - Wishbone single-word mailbox with TX/RX word FIFOs and sticky error flags
module s5_mbox #(
    parameter int DEPTH = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   wb_cyc_i,
    input  logic                   wb_stb_i,
    input  logic                   wb_we_i,
    input  logic [3:0]             wb_sel_i,
    input  logic [31:0]            wb_dat_i,
    output logic                   wb_ack_o,
    output logic [31:0]            wb_dat_o,
    output logic                   wb_stall_o,
    output logic                   wb_err_o,
    output logic [31:0]            tx_data_o,
    output logic                   tx_valid_o,
    input  logic                   tx_ready_i,
    input  logic [31:0]            rx_data_i,
    input  logic                   rx_valid_i,
    output logic                   rx_ready_o,
    output logic [$clog2(DEPTH):0] tx_level_o,
    output logic [$clog2(DEPTH):0] rx_level_o,
    output logic                   ovf_o,
    output logic                   udf_o,
    input  logic                   clr_i
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    logic [31:0]   tx_mem [DEPTH];
    logic [31:0]   rx_mem [DEPTH];

    logic [AW-1:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
    logic [AW-1:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
    logic [LW-1:0] tx_level_q, tx_level_d, rx_level_q, rx_level_d;
    logic          ack_q, ack_d;
    logic [31:0]   dat_q, dat_d;
    logic          ovf_q, ovf_d, udf_q, udf_d;

    logic          req, wr_req, rd_req;
    logic          tx_full, tx_empty, rx_full, rx_empty;
    logic          tx_push, tx_pop, rx_push, rx_pop;
    logic [31:0]   wr_data;

    // Full/empty come from the registered levels, so they reflect the state
    // before any push or pop happening on the same edge.
    always_comb begin
        req      = wb_cyc_i & wb_stb_i & ~ack_q;
        wr_req   = req & wb_we_i;
        rd_req   = req & ~wb_we_i;
        tx_full  = (tx_level_q == FULL);
        tx_empty = (tx_level_q == '0);
        rx_full  = (rx_level_q == FULL);
        rx_empty = (rx_level_q == '0);
        tx_push  = wr_req & ~tx_full;
        tx_pop   = ~tx_empty & tx_ready_i;
        rx_push  = rx_valid_i & ~rx_full;
        rx_pop   = rd_req & ~rx_empty;
        wr_data  = '0;
        for (int b = 0; b < 4; b++) begin
            wr_data[8*b +: 8] = wb_sel_i[b] ? wb_dat_i[8*b +: 8] : 8'h00;
        end
    end

    always_comb begin
        tx_wr_ptr_d = tx_push ? tx_wr_ptr_q + AW'(1) : tx_wr_ptr_q;
        tx_rd_ptr_d = tx_pop  ? tx_rd_ptr_q + AW'(1) : tx_rd_ptr_q;
        rx_wr_ptr_d = rx_push ? rx_wr_ptr_q + AW'(1) : rx_wr_ptr_q;
        rx_rd_ptr_d = rx_pop  ? rx_rd_ptr_q + AW'(1) : rx_rd_ptr_q;

        tx_level_d = tx_level_q;
        if (tx_push && !tx_pop) begin
            tx_level_d = tx_level_q + LW'(1);
        end else if (tx_pop && !tx_push) begin
            tx_level_d = tx_level_q - LW'(1);
        end

        rx_level_d = rx_level_q;
        if (rx_push && !rx_pop) begin
            rx_level_d = rx_level_q + LW'(1);
        end else if (rx_pop && !rx_push) begin
            rx_level_d = rx_level_q - LW'(1);
        end

        ack_d = req;
        dat_d = dat_q;
        if (rd_req) begin
            dat_d = rx_empty ? 32'h0 : rx_mem[rx_rd_ptr_q];
        end

        // A set event on the same edge as clr_i keeps the flag high.
        ovf_d = (wr_req & tx_full)  ? 1'b1 : (clr_i ? 1'b0 : ovf_q);
        udf_d = (rd_req & rx_empty) ? 1'b1 : (clr_i ? 1'b0 : udf_q);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tx_wr_ptr_q <= '0;
            tx_rd_ptr_q <= '0;
            rx_wr_ptr_q <= '0;
            rx_rd_ptr_q <= '0;
            tx_level_q  <= '0;
            rx_level_q  <= '0;
            ack_q       <= 1'b0;
            dat_q       <= '0;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
        end else begin
            tx_wr_ptr_q <= tx_wr_ptr_d;
            tx_rd_ptr_q <= tx_rd_ptr_d;
            rx_wr_ptr_q <= rx_wr_ptr_d;
            rx_rd_ptr_q <= rx_rd_ptr_d;
            tx_level_q  <= tx_level_d;
            rx_level_q  <= rx_level_d;
            ack_q       <= ack_d;
            dat_q       <= dat_d;
            ovf_q       <= ovf_d;
            udf_q       <= udf_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (tx_push) begin
            tx_mem[tx_wr_ptr_q] <= wr_data;
        end
        if (rx_push) begin
            rx_mem[rx_wr_ptr_q] <= rx_data_i;
        end
    end

    assign wb_ack_o   = ack_q;
    assign wb_dat_o   = dat_q;
    assign wb_stall_o = 1'b0;
    assign wb_err_o   = 1'b0;
    assign tx_valid_o = ~tx_empty;
    assign tx_data_o  = tx_mem[tx_rd_ptr_q];
    assign rx_ready_o = ~rx_full;
    assign tx_level_o = tx_level_q;
    assign rx_level_o = rx_level_q;
    assign ovf_o      = ovf_q;
    assign udf_o      = udf_q;
endmodule
